// File: rtl/fft_stage_scheduler.sv
// Radix-2 DIT FFT butterfly scheduler: one butterfly per cycle, write-back PIPE_LAT cycles after issue.
// hold stalls issue only; the write pipeline keeps shifting and a PIPE_LAT-cycle drain separates stages.
module fft_stage_scheduler #(
    parameter int LOG2N    = 3,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic [3:0]       stage,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [3:0]       wr_stage
);

    localparam int KW = LOG2N - 1;
    localparam int CW = $clog2(PIPE_LAT + 1);
    localparam logic [KW-1:0] K_LAST   = '1;
    localparam logic [3:0]    S_LAST   = 4'(LOG2N - 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(PIPE_LAT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic             vld;
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
        logic [3:0]       st;
    } wb_t;

    state_t        state_q, state_d;
    logic [3:0]    s_q, s_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    wb_t           wb_q [PIPE_LAT];
    wb_t           wb_d [PIPE_LAT];

    logic [LOG2N-1:0] half, pos, grp, addr_a;
    logic [3:0]       tw_sh;

    // Butterfly k of stage s: pos within its group, grp selects the 2*half-wide block.
    always_comb begin
        half   = LOG2N'(1) << s_q;
        pos    = {1'b0, k_q} & (half - LOG2N'(1));
        grp    = {1'b0, k_q} >> s_q;
        addr_a = (grp << (s_q + 4'd1)) | pos;
        tw_sh  = S_LAST - s_q;
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_addr   = '0;
        stage     = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            S_ISSUE: begin
                rd_addr_a = addr_a;
                rd_addr_b = addr_a + half;
                tw_addr   = KW'(pos) << tw_sh;
                stage     = s_q;
                if (!hold) begin
                    rd_en = 1'b1;
                    k_d   = k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        state_d = S_DRAIN;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (s_q == S_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        s_d     = s_q + 4'd1;
                        k_d     = '0;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write pipeline shifts unconditionally so hold bubbles surface as wr_en=0.
    always_comb begin
        wb_d[0] = {rd_en, rd_addr_a, rd_addr_b, stage};
        for (int i = 1; i < PIPE_LAT; i++) begin
            wb_d[i] = wb_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                wb_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
        end
    end

    assign wr_en     = wb_q[PIPE_LAT-1].vld;
    assign wr_addr_a = wb_q[PIPE_LAT-1].a;
    assign wr_addr_b = wb_q[PIPE_LAT-1].b;
    assign wr_stage  = wb_q[PIPE_LAT-1].st;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Scoreboard bench: default instance (N=8, PIPE_LAT=2) and an N=16, PIPE_LAT=1 instance.
module tb_fft_stage_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start0 = 1'b0, hold0 = 1'b0, start1 = 1'b0, hold1 = 1'b0;

    logic       busy0, done0, rd_en0, wr_en0;
    logic [2:0] ra0, rb0, wa0, wb0;
    logic [1:0] tw0;
    logic [3:0] st0, wst0;

    logic       busy1, done1, rd_en1, wr_en1;
    logic [3:0] ra1, rb1, wa1, wb1;
    logic [2:0] tw1;
    logic [3:0] st1, wst1;

    fft_stage_scheduler #(.LOG2N(3), .PIPE_LAT(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .hold(hold0),
        .busy(busy0), .done(done0), .rd_en(rd_en0),
        .rd_addr_a(ra0), .rd_addr_b(rb0), .tw_addr(tw0), .stage(st0),
        .wr_en(wr_en0), .wr_addr_a(wa0), .wr_addr_b(wb0), .wr_stage(wst0)
    );

    fft_stage_scheduler #(.LOG2N(4), .PIPE_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .hold(hold1),
        .busy(busy1), .done(done1), .rd_en(rd_en1),
        .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_addr(tw1), .stage(st1),
        .wr_en(wr_en1), .wr_addr_a(wa1), .wr_addr_b(wb1), .wr_stage(wst1)
    );

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int st;
    } ev_t;

    ev_t rdq0[$], wrq0[$], rdq1[$], wrq1[$];
    int  busy_lo[2] = '{0, 0};
    int  busy_hi[2] = '{-1, -1};
    int  done_cyc[2];
    bit  got_done[2];
    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic push_ev(input int w, input bit is_wr, input ev_t e);
        if (w == 0) begin
            if (is_wr) wrq0.push_back(e); else rdq0.push_back(e);
        end else begin
            if (is_wr) wrq1.push_back(e); else rdq1.push_back(e);
        end
    endtask

    // Expected schedule, enumerated group-by-group; hold cycles in [hlo,hhi] delay issue.
    task automatic gen(input int w, input int log2n, input int plat, input int c0,
                       input int hlo, input int hhi);
        int  n, t, half;
        ev_t e;
        n = 1 << log2n;
        t = c0 + 1;
        for (int s = 0; s < log2n; s++) begin
            half = 1 << s;
            for (int grp = 0; grp < n / (2 * half); grp++) begin
                for (int pos = 0; pos < half; pos++) begin
                    while (t >= hlo && t <= hhi) t++;
                    e.cyc = t;
                    e.a   = grp * 2 * half + pos;
                    e.b   = e.a + half;
                    e.tw  = pos * (n / (2 * half));
                    e.st  = s;
                    push_ev(w, 1'b0, e);
                    e.cyc = t + plat;
                    push_ev(w, 1'b1, e);
                    t++;
                end
            end
            t += plat;
        end
        busy_lo[w]  = c0 + 1;
        busy_hi[w]  = t;
        got_done[w] = 1'b0;
    endtask

    task automatic mon(input int w, input logic rd, input int ra, input int rb, input int tw,
                       input int st, input logic wr, input int wa, input int wb, input int wst,
                       input logic bsy, input logic dn);
        ev_t   e;
        string p;
        int    qs;
        p = (w == 0) ? "d0" : "d1";
        if (rd) begin
            qs = (w == 0) ? rdq0.size() : rdq1.size();
            if (qs == 0) begin
                check({p, "_rd_en_unexpected"}, int'(rd), 0);
            end else begin
                if (w == 0) e = rdq0.pop_front(); else e = rdq1.pop_front();
                check({p, "_rd_cycle"}, cyc, e.cyc);
                check({p, "_rd_addr_a"}, ra, e.a);
                check({p, "_rd_addr_b"}, rb, e.b);
                check({p, "_tw_addr"}, tw, e.tw);
                check({p, "_stage"}, st, e.st);
            end
        end
        if (wr) begin
            qs = (w == 0) ? wrq0.size() : wrq1.size();
            if (qs == 0) begin
                check({p, "_wr_en_unexpected"}, int'(wr), 0);
            end else begin
                if (w == 0) e = wrq0.pop_front(); else e = wrq1.pop_front();
                check({p, "_wr_cycle"}, cyc, e.cyc);
                check({p, "_wr_addr_a"}, wa, e.a);
                check({p, "_wr_addr_b"}, wb, e.b);
                check({p, "_wr_stage"}, wst, e.st);
            end
        end
        check({p, "_busy"}, int'(bsy), int'(cyc >= busy_lo[w] && cyc <= busy_hi[w]));
        check({p, "_done"}, int'(dn), int'(cyc == busy_hi[w]));
        if (dn) begin
            got_done[w] = 1'b1;
            done_cyc[w] = cyc;
        end
    endtask

    always @(negedge clk) begin
        mon(0, rd_en0, int'(ra0), int'(rb0), int'(tw0), int'(st0),
            wr_en0, int'(wa0), int'(wb0), int'(wst0), busy0, done0);
        mon(1, rd_en1, int'(ra1), int'(rb1), int'(tw1), int'(st1),
            wr_en1, int'(wa1), int'(wb1), int'(wst1), busy1, done1);
    end

    task automatic kick(input int w, input int hlo_rel, input int hhi_rel, output int c0);
        @(posedge clk);
        #1;
        c0 = cyc;
        if (w == 0) begin
            gen(0, 3, 2, c0, c0 + hlo_rel, c0 + hhi_rel);
            start0 = 1'b1;
        end else begin
            gen(1, 4, 1, c0, c0 + hlo_rel, c0 + hhi_rel);
            start1 = 1'b1;
        end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int w, input int c0, input int exp_rel, input string tag);
        int qr, qw;
        for (int i = 0; i < 300 && !got_done[w]; i++) @(posedge clk);
        check({tag, "_done_cycle"}, got_done[w] ? done_cyc[w] - c0 : -1, exp_rel);
        repeat (4) @(posedge clk);
        qr = (w == 0) ? rdq0.size() : rdq1.size();
        qw = (w == 0) ? wrq0.size() : wrq1.size();
        check({tag, "_reads_missing"}, qr, 0);
        check({tag, "_writes_missing"}, qw, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c0;
        #1 rst = 1'b1;
        #3;
        check("rst_rd_en", int'(rd_en0), 0);
        check("rst_wr_en", int'(wr_en0), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_rd_addr_b", int'(rb0), 0);
        check("rst_wr_stage", int'(wst0), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Plain transform
        kick(0, -10, -11, c0);
        wait_done(0, c0, 19, "plain");

        // Hold during stage 0 cycles 2-3
        kick(0, 2, 3, c0);
        @(posedge clk);
        #1 hold0 = 1'b1;
        repeat (2) @(posedge clk);
        #1 hold0 = 1'b0;
        wait_done(0, c0, 21, "hold");

        // Second start while busy must be ignored
        kick(0, -10, -11, c0);
        repeat (4) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        wait_done(0, c0, 19, "restart_ignored");

        // Asynchronous reset mid-cycle while both a read and a write are active
        kick(0, -10, -11, c0);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        rdq0.delete();
        wrq0.delete();
        busy_lo[0] = 0;
        busy_hi[0] = -1;
        #1;
        check("async_rst_rd_en", int'(rd_en0), 0);
        check("async_rst_wr_en", int'(wr_en0), 0);
        check("async_rst_busy", int'(busy0), 0);
        check("async_rst_done", int'(done0), 0);
        check("async_rst_rd_addr_a", int'(ra0), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        kick(0, -10, -11, c0);
        wait_done(0, c0, 19, "after_rst");

        // N=16, PIPE_LAT=1
        kick(1, -10, -11, c0);
        wait_done(1, c0, 37, "n16");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
